bep_frame_encoder: RTL and testbench



---
 rtl/bep_frame_pkg.sv | 40 ++++
 rtl/bep_frame_encoder_half_bit_timer.sv | 31 +++
 rtl/bep_frame_encoder.sv | 155 +++++++++++++++
 tb/tb_bep_frame_encoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bep_frame_pkg.sv
// Shared definitions for the BEP thermostat frame encoder: field widths,
// default fixed-field values, encoder state encoding and the frame packer.
package bep_frame_pkg;

  localparam int FRAME_BITS = 192;
  localparam int PREAMBLE_W = 32;
  localparam int TYPE_W     = 16;
  localparam int CONST_W    = 32;
  localparam int ID_W       = 32;
  localparam int TEMP_W     = 16;
  localparam int BYTE_W     = 8;

  localparam logic [PREAMBLE_W-1:0] DEF_PREAMBLE = 32'hAAAA_AAAB;
  localparam logic [CONST_W-1:0]    DEF_CONSTANT = 32'h0040_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } enc_state_e;

  // Field order on the wire, most significant field first.
  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic [PREAMBLE_W-1:0] preamble,
    input logic [TYPE_W-1:0]     type_1,
    input logic [TYPE_W-1:0]     type_2,
    input logic [CONST_W-1:0]    const_word,
    input logic [ID_W-1:0]       thermostat_id,
    input logic [TEMP_W-1:0]     room_temp,
    input logic [TEMP_W-1:0]     set_temp,
    input logic [BYTE_W-1:0]     state_byte,
    input logic [BYTE_W-1:0]     tail_1,
    input logic [BYTE_W-1:0]     tail_2,
    input logic [BYTE_W-1:0]     tail_3
  );
    return {preamble, type_1, type_2, const_word, thermostat_id,
            room_temp, set_temp, state_byte, tail_1, tail_2, tail_3};
  endfunction

endpackage

// File: rtl/bep_frame_encoder_half_bit_timer.sv
// Half-bit pacing counter for the BEP frame encoder. While enabled it
// counts down from HALF_BIT_CYCLES-1 and raises tick in the last cycle of
// each half-bit; while disabled it sits preloaded so the first half after
// enabling is full length.
module half_bit_timer #(
  parameter int HALF_BIT_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(HALF_BIT_CYCLES - 1);

  logic [7:0] cnt;

  assign tick = en && (cnt == 8'd0);

  // Down-count while enabled, reload at every half-bit boundary.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (!en || cnt == 8'd0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

endmodule

// File: rtl/bep_frame_encoder.sv
// BEP thermostat frame encoder: accepts one frame of field values over a
// valid/ready handshake, then shifts the 192-bit frame out MSB-first as
// Manchester code (1 = low then high, 0 = high then low), followed by an
// idle gap of GAP_BITS bit periods.
// Optional build macro: BEP_TX_BIT_CLOCK_EN adds a bit_clock output that is
// high during the second half of every transmitted bit.
module bep_frame_encoder
  import bep_frame_pkg::*;
#(
  parameter int          HALF_BIT_CYCLES = 4,
  parameter int          GAP_BITS        = 4,
  parameter logic [31:0] PREAMBLE        = DEF_PREAMBLE,
  parameter logic [31:0] CONSTANT        = DEF_CONSTANT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [15:0] type_1,
  input  logic [15:0] type_2,
  input  logic [31:0] thermostat_id,
  input  logic [15:0] room_temp,
  input  logic [15:0] set_temp,
  input  logic [7:0]  state,
  input  logic [7:0]  tail_1,
  input  logic [7:0]  tail_2,
  input  logic [7:0]  tail_3,
  output logic        tx_data,
  output logic        busy,
  output logic        frame_done
`ifdef BEP_TX_BIT_CLOCK_EN
  , output logic      bit_clock
`endif
);

  // Gap length in half-bits, minus one for a count-to-zero compare.
  localparam logic [8:0] GAP_LOAD = (GAP_BITS == 0) ? 9'd0 : 9'(2 * GAP_BITS - 1);
  localparam logic [7:0] LAST_BIT = 8'(FRAME_BITS - 1);

  enc_state_e            tx_state;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [FRAME_BITS-1:0] frame_word;
  logic [7:0]            bit_cnt;
  logic                  second_half;
  logic [8:0]            gap_cnt;
  logic                  half_tick;
  logic                  timer_en;
  logic                  accept;

  assign frame_word = pack_frame(PREAMBLE, type_1, type_2, CONSTANT, thermostat_id,
                                 room_temp, set_temp, state, tail_1, tail_2, tail_3);
  assign accept     = (tx_state == IDLE) && frame_valid && frame_ready;
  assign timer_en   = (tx_state != IDLE);

  half_bit_timer #(
    .HALF_BIT_CYCLES (HALF_BIT_CYCLES)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .en    (timer_en),
    .tick  (half_tick)
  );

  // Encoder FSM: handshake, serializer, Manchester line driver and gap timing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state    <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= 8'd0;
      second_half <= 1'b0;
      gap_cnt     <= 9'd0;
      tx_data     <= 1'b0;
      frame_ready <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (tx_state)
        IDLE: begin
          frame_ready <= 1'b1;
          busy        <= 1'b0;
          tx_data     <= 1'b0;
          if (accept) begin
            // The first half of the MSB goes out in the very next cycle.
            shift_reg   <= frame_word;
            bit_cnt     <= LAST_BIT;
            second_half <= 1'b0;
            tx_data     <= ~frame_word[FRAME_BITS-1];
            frame_ready <= 1'b0;
            busy        <= 1'b1;
            tx_state    <= SEND;
          end
        end
        SEND: begin
          if (half_tick) begin
            if (!second_half) begin
              second_half <= 1'b1;
              tx_data     <= shift_reg[FRAME_BITS-1];
            end else begin
              second_half <= 1'b0;
              shift_reg   <= {shift_reg[FRAME_BITS-2:0], 1'b0};
              if (bit_cnt == 8'd0) begin
                tx_data    <= 1'b0;
                frame_done <= 1'b1;
                if (GAP_BITS == 0) begin
                  tx_state    <= IDLE;
                  busy        <= 1'b0;
                  frame_ready <= 1'b1;
                end else begin
                  tx_state <= GAP;
                  gap_cnt  <= GAP_LOAD;
                end
              end else begin
                bit_cnt <= bit_cnt - 8'd1;
                tx_data <= ~shift_reg[FRAME_BITS-2];
              end
            end
          end
        end
        GAP: begin
          tx_data <= 1'b0;
          if (half_tick) begin
            if (gap_cnt == 9'd0) begin
              tx_state    <= IDLE;
              busy        <= 1'b0;
              frame_ready <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt - 9'd1;
            end
          end
        end
        default: begin
          tx_state    <= IDLE;
          tx_data     <= 1'b0;
          busy        <= 1'b0;
          frame_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef BEP_TX_BIT_CLOCK_EN
  // Bit clock: rises at each mid-bit transition, falls at each bit boundary.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_clock <= 1'b0;
    end else if (tx_state != SEND) begin
      bit_clock <= 1'b0;
    end else if (half_tick) begin
      bit_clock <= ~second_half;
    end
  end
`endif

endmodule

// File: tb/tb_bep_frame_encoder.sv
// Self-checking bench for bep_frame_encoder. Two instances share one clock:
// u_dut0 (HALF_BIT_CYCLES=4, GAP_BITS=4) and u_dut1 (HALF_BIT_CYCLES=1,
// GAP_BITS=0). Expected frames are queued at acceptance and compared
// cycle by cycle against the line output.
module tb_bep_frame_encoder;

  localparam int H0 = 4, G0 = 4, H1 = 1, G1 = 0;

  typedef struct packed {
    logic [191:0] f;
    int           acc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  valid = 2'b00;
  logic [1:0]  ready, tx, busy, done;
`ifdef BEP_TX_BIT_CLOCK_EN
  logic [1:0]  bc;
`endif
  logic [15:0] f_t1 = '0, f_t2 = '0, f_rt = '0, f_st = '0;
  logic [31:0] f_id = '0;
  logic [7:0]  f_sb = '0, f_a = '0, f_b = '0, f_c = '0;

  int   cyc = 0;
  int   dc [2] = '{0, 0};
  int   checks = 0;
  int   failures = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (done[0]) dc[0] <= dc[0] + 1;
    if (done[1]) dc[1] <= dc[1] + 1;
  end

  bep_frame_encoder #(.HALF_BIT_CYCLES(H0), .GAP_BITS(G0)) u_dut0 (
    .clock(clock), .reset(reset), .frame_valid(valid[0]), .frame_ready(ready[0]),
    .type_1(f_t1), .type_2(f_t2), .thermostat_id(f_id), .room_temp(f_rt),
    .set_temp(f_st), .state(f_sb), .tail_1(f_a), .tail_2(f_b), .tail_3(f_c),
    .tx_data(tx[0]), .busy(busy[0]), .frame_done(done[0])
`ifdef BEP_TX_BIT_CLOCK_EN
    , .bit_clock(bc[0])
`endif
  );

  bep_frame_encoder #(.HALF_BIT_CYCLES(H1), .GAP_BITS(G1)) u_dut1 (
    .clock(clock), .reset(reset), .frame_valid(valid[1]), .frame_ready(ready[1]),
    .type_1(f_t1), .type_2(f_t2), .thermostat_id(f_id), .room_temp(f_rt),
    .set_temp(f_st), .state(f_sb), .tail_1(f_a), .tail_2(f_b), .tail_3(f_c),
    .tx_data(tx[1]), .busy(busy[1]), .frame_done(done[1])
`ifdef BEP_TX_BIT_CLOCK_EN
    , .bit_clock(bc[1])
`endif
  );

  task automatic check(input string tag, input logic [191:0] act, input logic [191:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, want);
    end
  endtask

  function automatic logic [191:0] tb_frame();
    return {32'hAAAA_AAAB, f_t1, f_t2, 32'h0040_0000, f_id, f_rt, f_st, f_sb, f_a, f_b, f_c};
  endfunction

  // Line level expected during half-bit hi (0-based) of frame f.
  function automatic logic exp_half(input logic [191:0] f, input int hi);
    logic b;
    b = f[191 - hi / 2];
    return (hi % 2 == 0) ? ~b : b;
  endfunction

  task automatic rand_fields();
    f_t1 = 16'($urandom); f_t2 = 16'($urandom); f_id = $urandom;
    f_rt = 16'($urandom); f_st = 16'($urandom); f_sb = 8'($urandom);
    f_a  = 8'($urandom);  f_b  = 8'($urandom);  f_c  = 8'($urandom);
  endtask

  // Raise valid and wait for acceptance; queue the expected frame.
  task automatic drive(input int d, input bit rnd, output int acc);
    exp_t e;
    int   n;
    n = 0;
    acc = -1;
    valid[d] = 1'b1;
    while (n < 5000) begin
      if (rnd) rand_fields();
      if (ready[d]) begin
        e.f = tb_frame();
        e.acc = cyc + 1;
        acc = e.acc;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        @(negedge clock);
        break;
      end
      @(negedge clock);
      n++;
    end
    if (acc < 0) check("accept_timeout", 1, 0);
  endtask

  // Follow one frame on instance d from its first cycle to its return to IDLE.
  task automatic recv(input int d);
    exp_t         e;
    int           h, g, w, n0, bad, viol, hi, bcbad;
    logic [191:0] got;
    logic [15:0]  first16;
    logic         fh;
    h = (d == 0) ? H0 : H1;
    g = (d == 0) ? G0 : G1;
    w = 0;
    while (((d == 0) ? q0.size() : q1.size()) == 0 && w < 5000) begin
      @(negedge clock);
      w++;
    end
    if (((d == 0) ? q0.size() : q1.size()) == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
    while (cyc < e.acc) @(negedge clock);
    check("busy_rise", {busy[d], ready[d]}, 2'b10);
    n0 = dc[d];
    bad = 0; viol = 0; bcbad = 0; got = '0; first16 = '0; fh = 1'b0;
    for (int c = 0; c < 384 * h; c++) begin
      while (cyc < e.acc + c) @(negedge clock);
      hi = c / h;
      if (tx[d] !== exp_half(e.f, hi)) bad++;
      if (c % h == h / 2) begin
        if (hi % 2 == 0) fh = tx[d];
        else begin
          got[191 - hi / 2] = tx[d];
          if (tx[d] === fh) viol++;
        end
      end
      if (c < 16) first16[15 - c] = tx[d];
`ifdef BEP_TX_BIT_CLOCK_EN
      if (bc[d] !== (hi % 2 == 1)) bcbad++;
`endif
    end
    check("frame_data", got, e.f);
    check("manchester", viol, 0);
    check("tx_shape", bad, 0);
    if (h == 4) check("first_bits", first16, 16'h0FF0);
`ifdef BEP_TX_BIT_CLOCK_EN
    check("bit_clock", bcbad, 0);
`endif
    while (cyc < e.acc + 384 * h) @(negedge clock);
    check("done_at", {done[d], tx[d]}, 2'b10);
    if (g == 0) check("ready_nogap", {ready[d], busy[d]}, 2'b10);
    else        check("busy_gap", {ready[d], busy[d]}, 2'b01);
    @(negedge clock);
    check("done_pulse", done[d], 0);
    check("done_count", dc[d] - n0, 1);
    if (g > 0) begin
      while (cyc < e.acc + 384 * h + 2 * g * h - 1) @(negedge clock);
      check("gap_ready_low", {ready[d], tx[d]}, 2'b00);
      @(negedge clock);
      check("ready_back", {ready[d], busy[d]}, 2'b10);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   a1, a2, n0, quiet;
    exp_t e;

    // Reset state and quiet idle.
    repeat (3) @(negedge clock);
    check("rst_outputs", {tx, busy, done, ready}, 8'h00);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_release", ready, 2'b11);
    quiet = 0;
    repeat (20) begin
      @(negedge clock);
      if (tx !== 2'b00 || busy !== 2'b00 || done !== 2'b00 || ready !== 2'b11) quiet++;
    end
    check("idle_quiet", quiet, 0);

    // Directed frame at HALF_BIT_CYCLES=4, GAP_BITS=4.
    f_t1 = 16'h1234; f_rt = 16'h00C8;
    drive(0, 1'b0, a1);
    valid[0] = 1'b0;
    f_t1 = 16'hFFFF; f_rt = 16'hFFFF;
    recv(0);

    // Random fields on the same instance.
    drive(0, 1'b1, a1);
    valid[0] = 1'b0;
    recv(0);

    // Back-to-back with valid held high, fields changing every cycle.
    fork
      begin
        drive(1, 1'b1, a1);
        drive(1, 1'b1, a2);
        valid[1] = 1'b0;
        check("b2b_spacing", a2 - a1, 384 * H1 + 1);
      end
      begin
        recv(1);
        recv(1);
      end
    join

    // Reset during bit 100; frame abandoned without frame_done.
    f_t1 = 16'h0; f_t2 = 16'h0; f_id = 32'h0; f_rt = 16'h0; f_st = 16'h0;
    f_sb = 8'h0; f_a = 8'h0; f_b = 8'h0; f_c = 8'h0;
    drive(0, 1'b0, a1);
    valid[0] = 1'b0;
    e = q0.pop_front();
    while (cyc < e.acc + 200 * H0 + 1) @(negedge clock);
    check("pre_reset_tx", tx[0], exp_half(e.f, 200));
    n0 = dc[0];
    reset = 1'b1;
    #1;
    check("rst_async", {tx[0], busy[0], ready[0], done[0]}, 4'b0000);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_abort", ready[0], 1'b1);
    repeat (10) @(negedge clock);
    check("no_done_abandon", dc[0] - n0, 0);

    // Fresh frame after the abort.
    f_t1 = 16'hBEEF; f_t2 = 16'h0001; f_id = 32'h1357_9BDF; f_rt = 16'h00D2;
    f_st = 16'h00C8; f_sb = 8'h5A; f_a = 8'hFF; f_b = 8'h00; f_c = 8'h81;
    drive(0, 1'b0, a1);
    valid[0] = 1'b0;
    recv(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
